alu_issue_stage: RTL and testbench



---
 rtl/alu_isa_pkg.sv | 54 +++++
 rtl/regfile_8x16.sv | 38 +++
 rtl/alu_issue_stage.sv | 177 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_isa_pkg.sv
// Purpose : ISA constants shared by the ALU issue stage and its register file.
//           Holds the datapath geometry, opcode encodings, instruction field
//           bit positions, flag bit indices and a small decode helper.
// Ports   : none (package).
package alu_isa_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int RF_AW  = 3;

  // Opcodes 0000..1011 go straight to the ALU as alu_control.
  localparam logic [3:0] OP_DIV  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_SHL  = 4'b0111;
  localparam logic [3:0] OP_SHR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  // Opcodes handled by the issue stage itself.
  localparam logic [3:0] OP_LDI  = 4'b1100;
  localparam logic [3:0] OP_NOP0 = 4'b1101;
  localparam logic [3:0] OP_NOP1 = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // Instruction field bit positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // Bit indices inside the 3-bit flags register {zero, carry, parity}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_P = 0;

  // True for every opcode that produces a register writeback
  // (all real ALU ops plus LDI).
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Purpose : 8 x 16 register file for the ALU issue stage. No hardwired zero
//           register; every entry is writable.
// Ports   : clk, rst      - clock, synchronous active-high reset (clears all)
//           ra1/ra2       - read addresses, rd1/rd2 combinational read data
//           we/wa/wd      - synchronous write enable, address, data
// Reads see the value stored before the current edge; any same-cycle bypass
// is the job of the issue stage.
module regfile_8x16
  import alu_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RF_AW-1:0]  ra1,
  input  logic [RF_AW-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RF_AW-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [NREGS];

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];

  // Reset takes priority so an in-flight write is dropped at the reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose : Single-issue decode / register-read / writeback stage wrapped
//           around an external combinational 16-bit ALU.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           instr_valid/instr/instr_ready - instruction handshake
//           resume                   - pulse that leaves the halted state
//           alu_a/alu_b/alu_control  - registered ALU inputs (EX register)
//           alu_result/alu_zero/alu_carry/alu_parity - ALU outputs
//           wb_valid/wb_addr/wb_data - writeback happening at the next edge
//           flags                    - registered {zero, carry, parity}
//           div0_err                 - sticky divide-by-zero error
//           halted                   - HALT state bit
//           retired                  - completed writeback count (wraps)
//
// Handshake: an instruction transfers on every rising edge where
// instr_valid and instr_ready are both high; instr_ready depends only on the
// halted state, never on instr_valid, and instr is ignored otherwise.
module alu_issue_stage
  import alu_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  input  logic              resume,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic [DATA_W:0]   alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_parity,
  output logic              wb_valid,
  output logic [RF_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        flags,
  output logic              div0_err,
  output logic              halted,
  output logic [15:0]       retired
);

  // Instruction fields.
  logic [3:0]       op;
  logic [RF_AW-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0] imm9;

  assign op   = instr[OP_MSB:OP_LSB];
  assign rd   = instr[RD_MSB:RD_LSB];
  assign rs1  = instr[RS1_MSB:RS1_LSB];
  assign rs2  = instr[RS2_MSB:RS2_LSB];
  assign imm9 = instr[IMM_MSB:IMM_LSB];

  // EX register and architectural state.
  logic              ex_valid_q;
  logic              ex_writes_q;
  logic [RF_AW-1:0]  ex_rd_q;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [3:0]        alu_ctl_q, alu_ctl_d;
  logic              writes_d;
  logic [2:0]        flags_q;
  logic              div0_err_q;
  logic              halted_q, halted_d;
  logic [15:0]       retired_q;

  logic              accept;
  logic              div0;
  logic              fwd_en;
  logic [DATA_W-1:0] rf_rd1, rf_rd2;
  logic [DATA_W-1:0] opa, opb;

  // Bit 16 of the result reaches the architecture only via alu_carry.
  logic unused_alu_msb;
  assign unused_alu_msb = alu_result[DATA_W];

  assign accept   = instr_valid & ~halted_q;
  assign div0     = ex_valid_q & (alu_ctl_q == OP_DIV) & (alu_b_q == '0);
  assign wb_valid = ex_valid_q & ex_writes_q & ~div0;
  assign fwd_en   = wb_valid;

  regfile_8x16 u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (wb_valid),
    .wa  (ex_rd_q),
    .wd  (alu_result[DATA_W-1:0])
  );

  // The in-flight result is not in the register file yet, so a dependent
  // instruction issued right behind it takes the ALU output directly. This
  // also covers a same-cycle write and read of one register.
  assign opa = (fwd_en && (ex_rd_q == rs1)) ? alu_result[DATA_W-1:0] : rf_rd1;
  assign opb = (fwd_en && (ex_rd_q == rs2)) ? alu_result[DATA_W-1:0] : rf_rd2;

  // Decode into next EX contents.
  always_comb begin
    alu_a_d   = opa;
    alu_b_d   = opb;
    alu_ctl_d = op;
    writes_d  = op_writes(op);
    case (op)
      OP_LDI: begin
        // LDI is an ADD of the zero-extended immediate and zero.
        alu_a_d   = {{(DATA_W-IMM_W){1'b0}}, imm9};
        alu_b_d   = '0;
        alu_ctl_d = OP_ADD;
      end
      OP_NOP0, OP_NOP1, OP_HALT: begin
        // Park the ALU on a benign ADD so no false divide-by-zero appears.
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_ctl_d = OP_ADD;
      end
      default: ;
    endcase
  end

  // HALT wins over a coincident resume: resume only acts once halted.
  always_comb begin
    halted_d = halted_q;
    if (accept && (op == OP_HALT)) begin
      halted_d = 1'b1;
    end else if (halted_q && resume) begin
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_writes_q <= 1'b0;
      ex_rd_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctl_q   <= OP_ADD;
      flags_q     <= 3'b000;
      div0_err_q  <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= 16'h0000;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_writes_q <= writes_d;
        ex_rd_q     <= rd;
        alu_a_q     <= alu_a_d;
        alu_b_q     <= alu_b_d;
        alu_ctl_q   <= alu_ctl_d;
      end
      if (wb_valid) begin
        flags_q[FLAG_Z] <= alu_zero;
        flags_q[FLAG_C] <= alu_carry;
        flags_q[FLAG_P] <= alu_parity;
        retired_q       <= retired_q + 16'd1;
      end
      if (div0) begin
        div0_err_q <= 1'b1;
      end
      halted_q <= halted_d;
    end
  end

  assign instr_ready = ~halted_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign wb_addr     = ex_rd_q;
  assign wb_data     = alu_result[DATA_W-1:0];
  assign flags       = flags_q;
  assign div0_err    = div0_err_q;
  assign halted      = halted_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage. A small combinational ALU stand-in
// (DIV/ADD/SUB, parity over all 17 result bits) closes the loop; every
// expected value below is hand-computed.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        resume;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_control;
  logic [16:0] alu_result;
  logic        alu_zero, alu_carry, alu_parity;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  flags;
  logic        div0_err;
  logic        halted;
  logic [15:0] retired;

  int n_vec  = 0;
  int n_miss = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .resume      (resume),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_parity  (alu_parity),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flags       (flags),
    .div0_err    (div0_err),
    .halted      (halted),
    .retired     (retired)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in
  always_comb begin
    alu_result = 17'h0;
    case (alu_control)
      4'b0000: alu_result = (alu_b == 16'h0) ? 17'h0 : {1'b0, alu_a / alu_b};
      4'b0001: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0010: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_result = 17'h0;
    endcase
    alu_zero   = (alu_result[15:0] == 16'h0);
    alu_carry  = alu_result[16];
    alu_parity = ^alu_result;
  end

  // Checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {4'hC, rd, imm};
  endfunction

  task automatic issue(input logic [15:0] w);
    instr_valid = 1'b1;
    instr       = w;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},    instr_ready, 1);
    check({pfx, "_wb_valid"}, wb_valid, 0);
    check({pfx, "_alu_a"},    alu_a, 0);
    check({pfx, "_alu_b"},    alu_b, 0);
    check({pfx, "_alu_ctl"},  alu_control, 4'b0001);
    check({pfx, "_flags"},    flags, 3'b000);
    check({pfx, "_div0"},     div0_err, 0);
    check({pfx, "_halted"},   halted, 0);
    check({pfx, "_retired"},  retired, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; resume = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("rst0");

    // Back-to-back LDI / LDI / ADD with forwarding of r2
    issue(enc_ldi(3'd1, 9'd5));
    check("ldi1_a",     alu_a, 5);
    check("ldi1_ctl",   alu_control, 4'b0001);
    check("ldi1_wbv",   wb_valid, 1);
    check("ldi1_wbaddr", wb_addr, 1);
    check("ldi1_wbdata", wb_data, 5);
    issue(enc_ldi(3'd2, 9'd3));
    check("ldi2_b",     alu_b, 0);
    issue(enc_r(4'b0001, 3'd3, 3'd1, 3'd2));
    check("add_a",      alu_a, 5);
    check("add_b_fwd",  alu_b, 3);
    check("add_wbdata", wb_data, 16'h0008);
    idle();
    check("add_flags",  flags, 3'b001);
    check("add_retired", retired, 3);

    // SUB underflow: 3 - 5
    issue(enc_r(4'b0010, 3'd4, 3'd2, 3'd1));
    check("sub_a",      alu_a, 3);
    check("sub_b",      alu_b, 5);
    check("sub_wbdata", wb_data, 16'hFFFE);
    idle();
    check("sub_flags",  flags, 3'b010);
    check("sub_retired", retired, 4);

    // Divide by zero
    issue(enc_r(4'b0000, 3'd5, 3'd1, 3'd0));
    check("div_wbv",    wb_valid, 0);
    check("div_err_pre", div0_err, 0);
    idle();
    check("div_err",    div0_err, 1);
    check("div_flags",  flags, 3'b010);
    check("div_retired", retired, 4);
    check("div_r5",     dut.u_rf.mem_q[5], 0);

    // Same-register dependency: r6 = 7; r6 = r6 + r6
    issue(enc_ldi(3'd6, 9'd7));
    issue(enc_r(4'b0001, 3'd6, 3'd6, 3'd6));
    check("dep_a_fwd",  alu_a, 7);
    check("dep_b_fwd",  alu_b, 7);
    check("dep_wbdata", wb_data, 14);
    idle();
    check("dep_r6",     dut.u_rf.mem_q[6], 14);
    check("dep_flags",  flags, 3'b001);
    check("dep_retired", retired, 6);
    check("div_err_sticky", div0_err, 1);

    // HALT accepted with a coincident resume: halt wins
    instr_valid = 1'b1; instr = 16'hF000; resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check("halt_halted", halted, 1);
    check("halt_ready",  instr_ready, 0);
    instr = enc_ldi(3'd7, 9'h055);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("halt_ready_c%0d", i), instr_ready, 0);
      check($sformatf("halt_wbv_c%0d", i), wb_valid, 0);
    end
    check("halt_r7",     dut.u_rf.mem_q[7], 0);
    check("halt_retired", retired, 6);
    instr_valid = 1'b0; resume = 1'b1;
    @(posedge clk);
    #1;
    resume = 1'b0;
    check("resume_ready",  instr_ready, 1);
    check("resume_halted", halted, 0);
    issue(enc_ldi(3'd6, 9'h1FF));
    check("ldi_max_a", alu_a, 16'h01FF);
    idle();
    check("ldi_max_r6",   dut.u_rf.mem_q[6], 16'h01FF);
    check("ldi_max_retired", retired, 7);

    // Reset with an ADD in flight
    issue(enc_r(4'b0001, 3'd7, 3'd1, 3'd2));
    check("inflight_wbv", wb_valid, 1);
    check("inflight_wbdata", wb_data, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_r7", dut.u_rf.mem_q[7], 0);
    check("midrst_r1", dut.u_rf.mem_q[1], 0);
    check_reset_outputs("midrst");
    rst = 1'b0;

    // Retire counter wrap
    instr_valid = 1'b1; instr = enc_ldi(3'd1, 9'd1);
    repeat (65535) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wrap_ffff", retired, 16'hFFFF);
    issue(enc_ldi(3'd1, 9'd2));
    idle();
    check("wrap_zero", retired, 16'h0000);
    check("wrap_r1",   dut.u_rf.mem_q[1], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
